// File: rtl/joypad_port.sv
// NES joypad port fed by two Dualshock pads plus UART-injected buttons, with serial shift-out to the NES.
// Optional per-button autofire (square -> B, triangle -> A) is built when AUTOFIRE_EN is defined.
module joypad_port #(
  parameter int FREQ        = 37800000,
  parameter int AUTOFIRE_HZ = 15
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] ds0_b0,
  input  logic [7:0] ds0_b1,
  input  logic [7:0] ds1_b0,
  input  logic [7:0] ds1_b1,
  input  logic [7:0] loader_btn,
  input  logic [7:0] loader_btn2,
  input  logic       strobe,
  input  logic [1:0] joy_clk,
  output logic [1:0] joy_data,
  output logic [7:0] nes_btn,
  output logic [7:0] nes_btn2
);

  // Dualshock RX bytes are active-low; result is R,L,D,U,Start,Select,B,A active-high.
  function automatic logic [7:0] map_pad(input logic [7:0] b0, input logic [7:0] b1);
    map_pad = ~{b0[5], b0[7], b0[6], b0[4], b0[3], b0[0], b1[6], b1[5]};
  endfunction

  function automatic logic [7:0] resolve(input logic [7:0] m);
    logic [7:0] r;
    r = m;
    if (r[7] && r[6]) r[7:6] = 2'b00;
    if (r[5] && r[4]) r[5:4] = 2'b00;
    resolve = r;
  endfunction

  // af_out: [0] port0 B, [1] port0 A, [2] port1 B, [3] port1 A
  logic [3:0] af_out;

  logic       unused_bits;
  assign unused_bits = ^{ds0_b0[2:1], ds1_b0[2:1], ds0_b1[3:0], ds1_b1[3:0]};

`ifdef AUTOFIRE_EN
  localparam int HP = FREQ / (2 * AUTOFIRE_HZ);
  localparam int CW = (HP > 1) ? $clog2(HP) : 1;

  logic [3:0]         af_held;
  logic [3:0]         af_phase_now;
  logic [3:0]         af_phase_q, af_phase_d;
  logic [3:0]         af_armed_q, af_armed_d;
  logic [3:0][CW-1:0] af_cnt_q, af_cnt_d;

  assign af_held = ~{ds1_b1[4], ds1_b1[7], ds0_b1[4], ds0_b1[7]};

  // The armed bit makes the very first held cycle fire immediately, before phase is registered.
  always_comb begin
    af_phase_now = '0;
    af_out       = '0;
    af_cnt_d     = '0;
    af_phase_d   = '0;
    af_armed_d   = '0;
    for (int u = 0; u < 4; u++) begin
      af_phase_now[u] = af_armed_q[u] ? af_phase_q[u] : 1'b1;
      af_out[u]       = af_held[u] & af_phase_now[u];
      if (af_held[u]) begin
        af_armed_d[u] = 1'b1;
        if (af_cnt_q[u] == CW'(HP - 1)) begin
          af_cnt_d[u]   = '0;
          af_phase_d[u] = ~af_phase_now[u];
        end else begin
          af_cnt_d[u]   = af_cnt_q[u] + CW'(1);
          af_phase_d[u] = af_phase_now[u];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      af_cnt_q   <= '0;
      af_phase_q <= '0;
      af_armed_q <= '0;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
      af_armed_q <= af_armed_d;
    end
  end
`else
  localparam int unused_hp = FREQ / (2 * AUTOFIRE_HZ);
  logic unused_af;
  assign unused_af = ^{ds0_b1[7], ds0_b1[4], ds1_b1[7], ds1_b1[4]};
  assign af_out    = '0;
`endif

  logic [7:0]      nes_btn_q, nes_btn_d;
  logic [7:0]      nes_btn2_q, nes_btn2_d;
  logic [1:0]      joy_clk_q, joy_clk_d;
  logic [1:0][7:0] sr_q, sr_d;
  logic [1:0]      fall;

  assign fall = joy_clk_q & ~joy_clk;

  // Strobe reloads from the registered buttons and overrides any coincident falling edge.
  always_comb begin
    nes_btn_d  = resolve(map_pad(ds0_b0, ds0_b1) | {6'b0, af_out[0], af_out[1]} | loader_btn);
    nes_btn2_d = resolve(map_pad(ds1_b0, ds1_b1) | {6'b0, af_out[2], af_out[3]} | loader_btn2);
    joy_clk_d  = joy_clk;
    sr_d       = sr_q;
    if (strobe) begin
      sr_d[0] = nes_btn_q;
      sr_d[1] = nes_btn2_q;
    end else begin
      if (fall[0]) sr_d[0] = {1'b1, sr_q[0][7:1]};
      if (fall[1]) sr_d[1] = {1'b1, sr_q[1][7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      nes_btn_q  <= '0;
      nes_btn2_q <= '0;
      joy_clk_q  <= '0;
      sr_q       <= '0;
    end else begin
      nes_btn_q  <= nes_btn_d;
      nes_btn2_q <= nes_btn2_d;
      joy_clk_q  <= joy_clk_d;
      sr_q       <= sr_d;
    end
  end

  assign nes_btn  = nes_btn_q;
  assign nes_btn2 = nes_btn2_q;
  assign joy_data = {sr_q[1][0], sr_q[0][0]};

endmodule

// File: doc/joypad_port.md
JOYPAD_PORT -- requirements
Module: joypad_port

Interface
REQ-001 The block SHALL expose parameter FREQ, default 37800000, meaning clk frequency in Hz.
REQ-002 The block SHALL expose parameter AUTOFIRE_HZ, default 15, meaning autofire press rate in Hz.
REQ-003 clk  input  1  system clock; one clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 ds0_b0, ds0_b1  input  8 each  Dualshock port-1 RX bytes 0/1, active-low.
REQ-006 ds1_b0, ds1_b1  input  8 each  Dualshock port-2 RX bytes 0/1, active-low.
REQ-007 loader_btn, loader_btn2  input  8 each  UART-injected NES buttons, active-high.
REQ-008 strobe  input  1  NES joypad strobe.
REQ-009 joy_clk  input  2  NES joypad read clocks; bit i serves port i.
REQ-010 joy_data  output  2  serial button bit to NES; bit i from port i.
REQ-011 nes_btn, nes_btn2  output  8 each  merged buttons per port, active-high, for menu/loader use.

Function
REQ-012 NES button order SHALL be bit7..0 = Right, Left, Down, Up, Start, Select, B, A.
REQ-013 Mapping SHALL be: byte0 bit5 -> Right, bit7 -> Left, bit6 -> Down, bit4 -> Up, bit3 -> Start, bit0 -> Select; byte1 bit6 (X) -> B, bit5 (O) -> A; all inverted to active-high.
REQ-014 byte1 bit7 (square) SHALL drive autofire B; byte1 bit4 (triangle) SHALL drive autofire A; each ORed into its button.
REQ-015 Each port SHALL OR loader_btn(2) into its mapped value.
REQ-016 After merging, Left+Right both set SHALL clear both; Up+Down both set SHALL clear both.
REQ-017 nes_btn/nes_btn2 SHALL be registered: 1-cycle latency from input change.
REQ-018 Each port SHALL hold an 8-bit shift register; joy_data[i] SHALL equal its bit 0.
REQ-019 While strobe=1, each shift register SHALL load the registered nes_btn value every cycle.
REQ-020 Each port SHALL register joy_clk[i]; a falling edge (prev 1, now 0) with strobe=0 SHALL shift right, filling bit 7 with 1.
REQ-021 After 8 shifts without reload, joy_data[i] SHALL read 1 indefinitely.
REQ-022 Strobe=1 coincident with a falling edge: load SHALL win, no shift.
REQ-023 Ports SHALL be independent; simultaneous edges on both ports SHALL shift both.
REQ-024 Each autofire unit SHALL hold a counter and a phase bit; half-period HP = FREQ/(2*AUTOFIRE_HZ) cycles.
REQ-025 Source released: counter=0, phase=0, output 0.
REQ-026 On the first held cycle phase SHALL become 1; output = held AND phase.
REQ-027 While held, counter SHALL count 0..HP-1, then wrap to 0 and toggle phase.
REQ-028 Counter width SHALL be $clog2(HP) bits; no overflow beyond HP-1.

Reset
REQ-029 resetn=0 at a clock edge SHALL clear shift registers, joy_clk history, nes_btn, nes_btn2, autofire counters and phases; joy_data=2'b00.
REQ-030 Reset asserted mid-shift SHALL abandon the sequence; first post-reset strobe reloads normally.
REQ-031 Inputs SHALL be ignored while resetn=0.

Configuration
REQ-032 Macro AUTOFIRE_EN defined: autofire units present per REQ-014, REQ-024..028.
REQ-033 AUTOFIRE_EN undefined: no autofire logic; square/triangle ignored; all else unchanged.

Verification (FREQ=1000, AUTOFIRE_HZ=100, HP=5)
REQ-034 ds0_b1=8'hDF (O held), strobe 1->0, 8 falling joy_clk[0] -> joy_data[0] sequence 1,0,0,0,0,0,0,0 then 1 on 9th+ read.
REQ-035 ds0_b0=8'h5F (Left+Right held) -> nes_btn=8'h00 two cycles later; ds0_b0=8'h7F -> nes_btn=8'h40.
REQ-036 Strobe held 1 with joy_clk[0] toggling -> joy_data[0] stays bit0 of nes_btn; no shift observed.
REQ-037 ds0_b1=8'hEF (triangle) held 30 cycles with AUTOFIRE_EN -> nes_btn[0] pattern 5 high, 5 low, repeating; without macro -> 0 throughout.
REQ-038 loader_btn2=8'h08, reset pulsed after 3 shifts on port 2 -> joy_data=2'b00 during reset; next strobe reloads 8'h08.
